// File: rtl/home_inventory_wb_master.sv
// -----------------------------------------------------------------------------
// home_inventory_wb_master
//
// Single-outstanding Wishbone classic initiator. A command taken from the
// valid/ready command stream becomes exactly one Wishbone cycle. The block then
// waits for acknowledge, giving up after TIMEOUT strobe cycles. The outcome is
// returned on a valid/ready response stream. Saturating counters record
// completed and abandoned transactions for bring-up and debug.
//
// Parameters
//   TIMEOUT  strobe-high cycles without ack before the cycle is abandoned (1..255)
//   CNT_W    width of the transaction / timeout counters
//
// Ports
//   wb_clk_i, wb_rst_n_i         clock (rising edge), async active-low reset
//   cmd_valid_i / cmd_ready_o    command handshake
//   cmd_we_i, cmd_adr_i,
//   cmd_dat_i, cmd_sel_i         command payload (write flag, byte address,
//                                write data, byte strobes)
//   rsp_valid_o / rsp_ready_i    response handshake
//   rsp_dat_o, rsp_timeout_o     read data (0 for writes/timeouts), timeout flag
//   wbm_cyc_o .. wbm_sel_o       Wishbone initiator outputs, all registered
//   wbm_ack_i, wbm_dat_i         Wishbone acknowledge and read data
//   busy_o                       engine is not idle
//   txn_count_o                  acked transactions, saturating
//   timeout_count_o              abandoned transactions, saturating
// -----------------------------------------------------------------------------
module home_inventory_wb_master #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_we_i,
  input  logic [31:0]      cmd_adr_i,
  input  logic [31:0]      cmd_dat_i,
  input  logic [3:0]       cmd_sel_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_dat_o,
  output logic             rsp_timeout_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  output logic [3:0]       wbm_sel_o,
  input  logic             wbm_ack_i,
  input  logic [31:0]      wbm_dat_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] txn_count_o,
  output logic [CNT_W-1:0] timeout_count_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // The strobe counter holds the number of completed no-ack cycles. The cycle
  // in which it equals TIMEOUT-1 is the TIMEOUT-th strobe cycle, so the
  // abandon happens at the end of that cycle.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == {CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + CNT_W'(1);
    end
    return r;
  endfunction

  state_t           state_r, state_s;
  logic             cmd_ready_r, cmd_ready_s;
  logic             busy_r, busy_s;
  logic             cyc_r, cyc_s;
  logic             stb_r, stb_s;
  logic             we_r, we_s;
  logic [31:0]      adr_r, adr_s;
  logic [31:0]      dat_r, dat_s;
  logic [3:0]       sel_r, sel_s;
  logic             rsp_valid_r, rsp_valid_s;
  logic [31:0]      rsp_dat_r, rsp_dat_s;
  logic             rsp_tmo_r, rsp_tmo_s;
  logic [7:0]       tmo_cnt_r, tmo_cnt_s;
  logic [CNT_W-1:0] txn_cnt_r, txn_cnt_s;
  logic [CNT_W-1:0] to_cnt_r, to_cnt_s;
  logic             ack_seen_s;

  // An ack only counts while our strobe is up; late acks are ignored.
  assign ack_seen_s = wbm_ack_i & stb_r;

  // Next-state and next-output computation for the whole engine.
  always_comb begin
    state_s     = state_r;
    cyc_s       = cyc_r;
    stb_s       = stb_r;
    we_s        = we_r;
    adr_s       = adr_r;
    dat_s       = dat_r;
    sel_s       = sel_r;
    rsp_valid_s = rsp_valid_r;
    rsp_dat_s   = rsp_dat_r;
    rsp_tmo_s   = rsp_tmo_r;
    tmo_cnt_s   = tmo_cnt_r;
    txn_cnt_s   = txn_cnt_r;
    to_cnt_s    = to_cnt_r;

    case (state_r)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          we_s      = cmd_we_i;
          adr_s     = cmd_adr_i;
          dat_s     = cmd_dat_i;
          sel_s     = cmd_sel_i;
          cyc_s     = 1'b1;
          stb_s     = 1'b1;
          tmo_cnt_s = 8'd0;
          state_s   = ST_BUS;
        end else begin
          state_s   = ST_IDLE;
        end
      end

      ST_BUS: begin
        // Ack is checked first so it wins over a coincident timeout.
        if (ack_seen_s) begin
          cyc_s       = 1'b0;
          stb_s       = 1'b0;
          we_s        = 1'b0;
          rsp_dat_s   = we_r ? 32'h0000_0000 : wbm_dat_i;
          rsp_tmo_s   = 1'b0;
          rsp_valid_s = 1'b1;
          txn_cnt_s   = sat_inc(txn_cnt_r);
          state_s     = ST_RESP;
        end else if (tmo_cnt_r == TMO_LAST) begin
          cyc_s       = 1'b0;
          stb_s       = 1'b0;
          we_s        = 1'b0;
          rsp_dat_s   = 32'h0000_0000;
          rsp_tmo_s   = 1'b1;
          rsp_valid_s = 1'b1;
          to_cnt_s    = sat_inc(to_cnt_r);
          state_s     = ST_RESP;
        end else begin
          tmo_cnt_s   = tmo_cnt_r + 8'd1;
          state_s     = ST_BUS;
        end
      end

      ST_RESP: begin
        // Response is held unchanged until the consumer takes it.
        if (rsp_ready_i) begin
          rsp_valid_s = 1'b0;
          state_s     = ST_IDLE;
        end else begin
          state_s     = ST_RESP;
        end
      end

      default: begin
        cyc_s       = 1'b0;
        stb_s       = 1'b0;
        we_s        = 1'b0;
        rsp_valid_s = 1'b0;
        state_s     = ST_IDLE;
      end
    endcase

    // Handshake/status flags are registered copies of the next state.
    cmd_ready_s = (state_s == ST_IDLE);
    busy_s      = (state_s != ST_IDLE);
  end

  // State register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Output and counter registers; reset drops cyc/stb asynchronously.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      cyc_r       <= 1'b0;
      stb_r       <= 1'b0;
      we_r        <= 1'b0;
      adr_r       <= 32'h0000_0000;
      dat_r       <= 32'h0000_0000;
      sel_r       <= 4'h0;
      rsp_valid_r <= 1'b0;
      rsp_dat_r   <= 32'h0000_0000;
      rsp_tmo_r   <= 1'b0;
      tmo_cnt_r   <= 8'd0;
      txn_cnt_r   <= {CNT_W{1'b0}};
      to_cnt_r    <= {CNT_W{1'b0}};
    end else begin
      cmd_ready_r <= cmd_ready_s;
      busy_r      <= busy_s;
      cyc_r       <= cyc_s;
      stb_r       <= stb_s;
      we_r        <= we_s;
      adr_r       <= adr_s;
      dat_r       <= dat_s;
      sel_r       <= sel_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_dat_r   <= rsp_dat_s;
      rsp_tmo_r   <= rsp_tmo_s;
      tmo_cnt_r   <= tmo_cnt_s;
      txn_cnt_r   <= txn_cnt_s;
      to_cnt_r    <= to_cnt_s;
    end
  end

  assign cmd_ready_o     = cmd_ready_r;
  assign busy_o          = busy_r;
  assign wbm_cyc_o       = cyc_r;
  assign wbm_stb_o       = stb_r;
  assign wbm_we_o        = we_r;
  assign wbm_adr_o       = adr_r;
  assign wbm_dat_o       = dat_r;
  assign wbm_sel_o       = sel_r;
  assign rsp_valid_o     = rsp_valid_r;
  assign rsp_dat_o       = rsp_dat_r;
  assign rsp_timeout_o   = rsp_tmo_r;
  assign txn_count_o     = txn_cnt_r;
  assign timeout_count_o = to_cnt_r;

endmodule

// File: tb/tb_home_inventory_wb_master.sv
// -----------------------------------------------------------------------------
// tb_home_inventory_wb_master
//
// Directed bench for home_inventory_wb_master. A small behavioural register
// slave (ID, VERSION, IRQ_EN) with a registered ack stands in for the real
// register block. A second instance with CNT_W=2 covers counter saturation.
// -----------------------------------------------------------------------------
module tb_home_inventory_wb_master;

  localparam logic [31:0] ADR_ID      = 32'h0000_0000;
  localparam logic [31:0] ADR_VERSION = 32'h0000_0004;
  localparam logic [31:0] ADR_IRQ_EN  = 32'h0000_0008;
  localparam logic [31:0] ID_VAL      = 32'h4849_4348;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [31:0] cmd_adr = 32'h0, cmd_dat = 32'h0;
  logic [3:0]  cmd_sel = 4'h0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_timeout;
  logic [31:0] rsp_dat;
  logic        cyc, stb, we, ack;
  logic [31:0] adr, wdat, rdat;
  logic [3:0]  sel;
  logic        busy;
  logic [15:0] txn_count, timeout_count;

  // second instance for saturation
  logic        cmd_valid2 = 1'b0, cmd_ready2, rsp_valid2, rsp_timeout2;
  logic [31:0] rsp_dat2, adr2, wdat2;
  logic        cyc2, stb2, we2, busy2;
  logic        ack2_r;
  logic [3:0]  sel2;
  logic [1:0]  txn_count2, timeout_count2;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  home_inventory_wb_master #(.TIMEOUT(16), .CNT_W(16)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
    .rsp_timeout_o(rsp_timeout),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_adr_o(adr),
    .wbm_dat_o(wdat), .wbm_sel_o(sel), .wbm_ack_i(ack), .wbm_dat_i(rdat),
    .busy_o(busy), .txn_count_o(txn_count), .timeout_count_o(timeout_count)
  );

  home_inventory_wb_master #(.TIMEOUT(16), .CNT_W(2)) dut_sat (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid2), .cmd_ready_o(cmd_ready2), .cmd_we_i(1'b0),
    .cmd_adr_i(ADR_ID), .cmd_dat_i(32'h0), .cmd_sel_i(4'hF),
    .rsp_valid_o(rsp_valid2), .rsp_ready_i(1'b1), .rsp_dat_o(rsp_dat2),
    .rsp_timeout_o(rsp_timeout2),
    .wbm_cyc_o(cyc2), .wbm_stb_o(stb2), .wbm_we_o(we2), .wbm_adr_o(adr2),
    .wbm_dat_o(wdat2), .wbm_sel_o(sel2), .wbm_ack_i(ack2_r), .wbm_dat_i(32'h0),
    .busy_o(busy2), .txn_count_o(txn_count2), .timeout_count_o(timeout_count2)
  );

  // Behavioural slave: registered ack one cycle after a new strobe.
  logic        ack_r, ack_en = 1'b1, late_ack = 1'b0;
  logic [2:0]  irq_en_r;
  logic [31:0] sdat_r;
  logic        req_s;
  assign req_s = cyc & stb & ~ack_r & ack_en;
  assign ack   = ack_r | late_ack;
  assign rdat  = sdat_r;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_r <= 1'b0; irq_en_r <= 3'd0; sdat_r <= 32'h0;
    end else begin
      ack_r <= req_s;
      if (req_s) begin
        if (we) begin
          if (adr == ADR_IRQ_EN && sel[0]) irq_en_r <= wdat[2:0];
        end else begin
          case (adr)
            ADR_ID:      sdat_r <= ID_VAL;
            ADR_VERSION: sdat_r <= 32'h0000_0001;
            ADR_IRQ_EN:  sdat_r <= {29'd0, irq_en_r};
            default:     sdat_r <= 32'h0;
          endcase
        end
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack2_r <= 1'b0;
    else        ack2_r <= cyc2 & stb2 & ~ack2_r;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One complete transaction with immediate response handshake.
  task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd,
                        output logic tmo, output int stb_cyc, output int overlap);
    @(negedge clk);
    chk("txn_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    stb_cyc = 0; overlap = 0;
    for (int i = 0; i < 100; i++) begin
      if (stb && rsp_valid) overlap++;
      if (stb) stb_cyc++;
      else if (rsp_valid) break;
      @(negedge clk);
    end
    chk("txn_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    rd = rsp_dat; tmo = rsp_timeout;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        tmo;
    int          sc, ov, bp_bad;

    vecs[0] = '{1'b0, ADR_ID,      32'h0,         4'hF, ID_VAL};
    vecs[1] = '{1'b1, ADR_IRQ_EN,  32'hFFFF_FFFF, 4'hF, 32'h0};
    vecs[2] = '{1'b0, ADR_IRQ_EN,  32'h0,         4'hF, 32'h0000_0007};
    vecs[3] = '{1'b1, ADR_IRQ_EN,  32'h0000_0005, 4'h1, 32'h0};
    vecs[4] = '{1'b0, ADR_IRQ_EN,  32'h0,         4'hF, 32'h0000_0005};
    vecs[5] = '{1'b1, ADR_IRQ_EN,  32'h0000_0000, 4'h2, 32'h0};
    vecs[6] = '{1'b0, ADR_IRQ_EN,  32'h0,         4'hF, 32'h0000_0005};
    vecs[7] = '{1'b0, ADR_VERSION, 32'h0,         4'hF, 32'h0000_0001};

    // reset state
    @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_busy",      {31'd0, busy}, 32'd0);
    chk("rst_wb",        {28'd0, cyc, stb, we, rsp_valid}, 32'd0);
    chk("rst_adr",       adr, 32'd0);
    chk("rst_rsp_dat",   rsp_dat, 32'd0);
    chk("rst_counts",    {txn_count, timeout_count}, 32'd0);
    rst_n = 1'b1;

    // table-driven transactions
    for (int i = 0; i < 8; i++) begin
      do_txn(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, rd, tmo, sc, ov);
      chk($sformatf("vec%0d_dat", i), rd, vecs[i].exp_dat);
      chk($sformatf("vec%0d_tmo", i), {31'd0, tmo}, 32'd0);
      chk($sformatf("vec%0d_stb_cycles", i), sc, 32'd2);
      chk($sformatf("vec%0d_overlap", i), ov, 32'd0);
    end
    chk("txn_count_after_table", {16'd0, txn_count}, 32'd8);
    chk("adr_held", adr, ADR_VERSION);
    chk("we_low_idle", {31'd0, we}, 32'd0);

    // timeout: slave never acks
    ack_en = 1'b0;
    do_txn(1'b0, ADR_ID, 32'h0, 4'hF, rd, tmo, sc, ov);
    chk("tmo_stb_cycles", sc, 32'd16);
    chk("tmo_flag", {31'd0, tmo}, 32'd1);
    chk("tmo_dat", rd, 32'd0);
    chk("tmo_overlap", ov, 32'd0);
    chk("tmo_count", {16'd0, timeout_count}, 32'd1);
    repeat (2) @(negedge clk);
    late_ack = 1'b1;
    @(negedge clk);
    late_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_counts", {txn_count, timeout_count}, {16'd8, 16'd1});
    chk("late_ack_idle", {29'd0, cyc, rsp_valid, busy}, 32'd0);
    ack_en = 1'b1;

    // response backpressure on a VERSION read
    @(negedge clk);
    cmd_we = 1'b0; cmd_adr = ADR_VERSION; cmd_sel = 4'hF; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (rsp_valid) break;
      @(negedge clk);
    end
    chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
    cmd_valid = 1'b1; cmd_adr = ADR_ID;
    bp_bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!rsp_valid || rsp_dat !== 32'h1 || cmd_ready || cyc || stb) bp_bad++;
    end
    chk("bp_hold", bp_bad, 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0; cmd_valid = 1'b0;
    chk("bp_release", {29'd0, busy, cmd_ready, rsp_valid}, 32'b010);

    // reset in the middle of a bus cycle
    ack_en = 1'b0;
    @(negedge clk);
    cmd_we = 1'b0; cmd_adr = ADR_ID; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("midbus_stb_high", {31'd0, stb}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midbus_rst_cyc_stb", {30'd0, cyc, stb}, 32'd0);
    chk("midbus_rst_counts", {txn_count, timeout_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; ack_en = 1'b1;
    do_txn(1'b0, ADR_ID, 32'h0, 4'hF, rd, tmo, sc, ov);
    chk("post_rst_id", rd, ID_VAL);
    chk("post_rst_txn_count", {16'd0, txn_count}, 32'd1);

    // saturation on the 2-bit counter instance
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cmd_valid2 = 1'b1;
      @(negedge clk);
      cmd_valid2 = 1'b0;
      repeat (4) @(negedge clk);
      if (i == 1) chk("sat_count_2", {30'd0, txn_count2}, 32'd2);
    end
    chk("sat_count_final", {30'd0, txn_count2}, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/home_inventory_wb_master.md
# home_inventory_wb_master

Single-outstanding Wishbone classic initiator: turns a valid/ready command stream (address, data, byte-select, read/write) into one Wishbone cycle, waits for acknowledge with a bounded timeout, and returns a response on a valid/ready stream. It sits between firmware-facing or on-chip sequencer logic and `home_inventory_wb`, driving that register block's slave port. Cycle counters support bring-up and debug.

## Interface
Parameters:
- `TIMEOUT`, default 16: number of stb-high cycles without ack before the cycle is abandoned; legal range 1..255.
- `CNT_W`, default 16: width of the transaction and timeout counters.

Ports:
- `wb_clk_i`  in  1  sole clock; all logic on the rising edge.
- `wb_rst_n_i`  in  1  reset, asynchronous assert, active-low.
- `cmd_valid_i`  in  1  command present.
- `cmd_ready_o`  out  1  command accepted when high with `cmd_valid_i`.
- `cmd_we_i`  in  1  1 = write, 0 = read.
- `cmd_adr_i`  in  32  byte address.
- `cmd_dat_i`  in  32  write data.
- `cmd_sel_i`  in  4  byte strobes.
- `rsp_valid_o`  out  1  response present.
- `rsp_ready_i`  in  1  response consumed when high with `rsp_valid_o`.
- `rsp_dat_o`  out  32  read data. Value is 0 for writes and timeouts.
- `rsp_timeout_o`  out  1  cycle abandoned without ack.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o`  out  1 each  Wishbone cycle, strobe and write-enable.
- `wbm_adr_o`  out  32  address. `wbm_dat_o`  out  32  write data. `wbm_sel_o`  out  4  byte select.
- `wbm_ack_i`  in  1  acknowledge. `wbm_dat_i`  in  32  read data.
- `busy_o`  out  1  state != IDLE.
- `txn_count_o`  out  CNT_W  completed (acked) transactions, saturating.
- `timeout_count_o`  out  CNT_W  timed-out transactions, saturating.

## Operation
- States: IDLE, BUS, RESP.
- IDLE:
  - `cmd_ready_o`=1.
  - On `cmd_valid_i`: latch we/adr/dat/sel into the `wbm_*` registers, set cyc=stb=1, clear the timeout counter, go to BUS.
- BUS:
  - `wbm_*` outputs are stable and come directly from registers.
  - On `wbm_ack_i`=1:
    - Drop cyc/stb/we.
    - Capture `rsp_dat_o` = `wbm_dat_i` for a read, or 0 for a write.
    - Set `rsp_timeout_o`=0 and `rsp_valid_o`=1.
    - Increment `txn_count_o`, then go to RESP.
  - Otherwise increment the timeout counter. When it reaches `TIMEOUT`:
    - Drop cyc/stb.
    - Set `rsp_dat_o`=0, `rsp_timeout_o`=1, `rsp_valid_o`=1.
    - Increment `timeout_count_o`, then go to RESP.
- RESP:
  - Hold all response outputs.
  - On `rsp_ready_i`: clear `rsp_valid_o` and go to IDLE.
  - `cmd_ready_o`=0. No bypass: the earliest next command is the cycle after the handshake.
- `wbm_ack_i` is ignored whenever `wbm_stb_o`=0, which includes a late ack after a timeout. Such an ack increments nothing.
- Ack and timeout in the same cycle: ack wins.
- Counters saturate at all-ones; they never wrap.
- `wbm_adr_o`, `wbm_dat_o` and `wbm_sel_o` hold their last value after the cycle ends. `wbm_we_o` returns to 0.

## Timing
- Reset values: state IDLE. Every output is 0 (`cmd_ready_o` follows IDLE, so it is 1 after reset), including all `wbm_*`, `rsp_*` and both counters.
- Reset during BUS or RESP aborts at once:
  - cyc/stb drop asynchronously.
  - A pending response is lost.
  - Counters clear.
- Command accepted at edge N: cyc/stb are high from N, visible for the cycle N..N+1.
- Slave acks (registered) in the cycle ending at edge N+k: cyc/stb are low after edge N+k, and `rsp_valid_o`=1 in the same cycle.
- The slave never sees stb asserted for a cycle after the one in which it acked.
- Timeout: stb is high for exactly `TIMEOUT` cycles, then `rsp_valid_o` rises as cyc/stb fall.
- Best case with `rsp_ready_i` tied high is 3 cycles per transaction: accept, ack, response handshake.

## Test plan
- Read ID against a real `home_inventory_wb`: cmd read `ADR_ID` -> `rsp_dat_o`=0x48494348, `rsp_timeout_o`=0, `txn_count_o`=1, stb high exactly one cycle past the ack edge at most.
- Write then read `ADR_IRQ_EN`:
  - Write 0xFFFFFFFF with sel=0xF, then read -> 0x00000007.
  - Write 0x5 with sel=0x1, then read -> 0x00000005.
  - The write responses have `rsp_dat_o`=0.
- Timeout: slave model never acks, `TIMEOUT`=16 -> stb high exactly 16 cycles, response has timeout=1 and data 0, `timeout_count_o`=1. A late ack 3 cycles later changes nothing.
- Response backpressure: hold `rsp_ready_i`=0 for 10 cycles after a read of `ADR_VERSION` -> `rsp_dat_o`=0x1 stable and valid throughout, `cmd_ready_o`=0, no new Wishbone cycle; release -> IDLE next edge.
- Reset mid-BUS: assert `wb_rst_n_i` low while stb is high -> cyc/stb=0 before the next edge, counters 0, and a following read of `ADR_ID` completes normally.
- Saturation with `CNT_W`=2: 5 acked commands -> `txn_count_o`=3.
